// File: rtl/ldpc_dec_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_dec_sched_if
//  Description : Bundle of the codeword input channels, the decoder-core
//                connection and the result port of the LDPC decoder
//                scheduler.
//                  in0_* / in1_*  : valid/ready codeword channels (12 bit)
//                  dec_*          : core reset, codeword and message (4 bit)
//                  res_*          : valid/ready result port with channel tag
//                  busy           : scheduler is not idle
//                modport master : scheduler side
//                modport slave  : environment side (sources, core, sink)
//  Revision    : 1.0  initial release
// ============================================================================
interface ldpc_dec_sched_if;
    logic        in0_valid;
    logic [11:0] in0_code;
    logic        in0_ready;
    logic        in1_valid;
    logic [11:0] in1_code;
    logic        in1_ready;
    logic        dec_rst_n;
    logic [11:0] dec_code;
    logic [3:0]  dec_msg;
    logic        res_valid;
    logic [3:0]  res_msg;
    logic        res_ch;
    logic        res_ready;
    logic        busy;

    modport master (
        input  in0_valid, in0_code,
        output in0_ready,
        input  in1_valid, in1_code,
        output in1_ready,
        output dec_rst_n, dec_code,
        input  dec_msg,
        output res_valid, res_msg, res_ch,
        input  res_ready,
        output busy
    );

    modport slave (
        output in0_valid, in0_code,
        input  in0_ready,
        output in1_valid, in1_code,
        input  in1_ready,
        input  dec_rst_n, dec_code,
        output dec_msg,
        input  res_valid, res_msg, res_ch,
        output res_ready,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/ldpc_dec_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_dec_sched
//  Description : Two-channel round-robin scheduler sharing one LDPC decoder
//                core. A granted codeword is latched onto dec_code, the core
//                is held in reset for the LOAD phase and then released so its
//                free-running window lines up with the frame; dec_msg is
//                sampled DEC_LAT cycles after release and returned with the
//                channel tag on the result port.
//  Ports       : clk, rst (synchronous, active-high)
//                bus  (ldpc_dec_sched_if.master): inputs, core, result, busy
//                frm_cnt0/frm_cnt1 : per-channel result counters, present
//                only when LDPC_SCHED_STATS_EN is defined
//  Options     : LDPC_SCHED_STATS_EN - adds the frame statistics counters
//  Revision    : 1.0  initial release
// ============================================================================
module ldpc_dec_sched #(
    parameter int DEC_LAT = 28,   // RUN cycles from core release to sampling
    parameter int RST_CYC = 1     // extra LOAD cycles with the core in reset
) (
    input  wire                   clk,
    input  wire                   rst,
    ldpc_dec_sched_if.master      bus
`ifdef LDPC_SCHED_STATS_EN
    ,
    output logic [15:0]           frm_cnt0,
    output logic [15:0]           frm_cnt1
`endif
);

    localparam int c_CNT_W = $clog2(DEC_LAT + RST_CYC + 1);
    // LOAD leaves when the counter reaches RST_CYC: with the registered
    // dec_rst_n this places core release at accept + 1 + RST_CYC.
    localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CNT_W'(RST_CYC);
    localparam logic [c_CNT_W-1:0] c_RUN_LAST  = c_CNT_W'(DEC_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_last;
    logic                 r_dec_rst_n;
    logic [11:0]          r_dec_code;
    logic                 r_res_valid;
    logic [3:0]           r_res_msg;
    logic                 r_res_ch;

    logic                 w_idle;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_acc0;
    logic                 w_acc1;

    // ------------------------------------------------------------------
    // Round-robin grant: a lone requester wins, on a tie the channel that
    // was not served last wins. Only meaningful while idle.
    // ------------------------------------------------------------------
    assign w_idle   = (r_state == S_IDLE);
    assign w_grant0 = bus.in0_valid && (!bus.in1_valid || r_last);
    assign w_grant1 = bus.in1_valid && (!bus.in0_valid || !r_last);
    assign w_acc0   = w_idle && w_grant0;
    assign w_acc1   = w_idle && w_grant1;

    assign bus.in0_ready = w_acc0;
    assign bus.in1_ready = w_acc1;
    assign bus.busy      = !w_idle;
    assign bus.dec_rst_n = r_dec_rst_n;
    assign bus.dec_code  = r_dec_code;
    assign bus.res_valid = r_res_valid;
    assign bus.res_msg   = r_res_msg;
    assign bus.res_ch    = r_res_ch;

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last      <= 1'b1;
            r_dec_rst_n <= 1'b0;
            r_dec_code  <= 12'h000;
            r_res_valid <= 1'b0;
            r_res_msg   <= 4'h0;
            r_res_ch    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc0 || w_acc1) begin
                        r_dec_code <= w_acc1 ? bus.in1_code : bus.in0_code;
                        r_res_ch   <= w_acc1;
                        r_last     <= w_acc1;
                        r_cnt      <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == c_LOAD_LAST) begin
                        r_cnt       <= '0;
                        r_dec_rst_n <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_cnt == c_RUN_LAST) begin
                        // Core has had DEC_LAT cycles out of reset; its
                        // message is settled, so capture it and park the core.
                        r_res_msg   <= bus.dec_msg;
                        r_res_valid <= 1'b1;
                        r_dec_rst_n <= 1'b0;
                        r_state     <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    // Returning to IDLE without granting here gives the
                    // bubble cycle between frames.
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LDPC_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Per-channel completed-frame counters (free wrap at 16 bits)
    // ------------------------------------------------------------------
    logic w_res_hs;
    assign w_res_hs = r_res_valid && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt0 <= 16'h0000;
            frm_cnt1 <= 16'h0000;
        end else if (w_res_hs) begin
            if (r_res_ch) begin
                frm_cnt1 <= frm_cnt1 + 16'h0001;
            end else begin
                frm_cnt0 <= frm_cnt0 + 16'h0001;
            end
        end
    end
`endif

endmodule
`default_nettype wire
